// File: rtl/pio_led_sequencer.sv
// rtl/pio_led_sequencer.sv - PIO command driven one-hot running-light sequencer
module pio_led_sequencer #(
  parameter int LED_W    = 4,
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  output logic [LED_W-1:0] led,
  output logic             running,
  output logic             step,
  output logic             wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [3:0]       cmd_q;
  // Only the direction/speed bits take part in change detection.
  logic [2:0]       cmd_p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] period;
  logic [LED_W-1:0] led_d;
  logic [LED_W-1:0] led_start;
  logic [LED_W-1:0] led_next;
  logic             step_d;
  logic             wrap_d;
  logic             tick;
  logic             changed;
  logic             at_end;

  // Step period scales the base divider by 1x/2x/4x/8x from the speed field.
  assign period    = CNT_W'(TICK_DIV) << cmd_q[1:0];
  assign tick      = (cnt == period - CNT_W'(1));
  assign changed   = (cmd_q[2:0] != cmd_p);
  // Start position depends on direction: LSB when moving up, MSB when moving down.
  assign led_start = cmd_q[2] ? {1'b1, {(LED_W-1){1'b0}}} : LED_W'(1);
  assign led_next  = cmd_q[2] ? {led[0], led[LED_W-1:1]} : {led[LED_W-2:0], led[LED_W-1]};
  assign at_end    = cmd_q[2] ? led[0] : led[LED_W-1];

  // State register plus registered datapath; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cmd_q <= 4'b0;
      cmd_p <= 3'b0;
      cnt   <= '0;
      led   <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_d;
      cmd_q <= cmd;
      cmd_p <= cmd_q[2:0];
      cnt   <= cnt_d;
      led   <= led_d;
      step  <= step_d;
      wrap  <= wrap_d;
    end
  end

  // Next-state: enable bit alone moves between IDLE and RUN.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_q[3]) state_d = RUN;
      RUN:     if (!cmd_q[3]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and next datapath values; disable beats change, change beats tick.
  always_comb begin
    running = (state == RUN);
    cnt_d   = '0;
    led_d   = '0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_q[3]) led_d = led_start;
      end
      RUN: begin
        if (!cmd_q[3]) begin
          led_d = '0;
        end else if (changed) begin
          led_d = led;
        end else if (tick) begin
          led_d  = led_next;
          step_d = 1'b1;
          wrap_d = at_end;
        end else begin
          led_d = led;
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        led_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pio_led_sequencer.sv
// tb/tb_pio_led_sequencer.sv - self-checking bench for pio_led_sequencer
module tb_pio_led_sequencer;

  localparam int LED_W    = 4;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic [3:0] led;
  logic       running;
  logic       step;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {led, running, step, wrap}
  logic [6:0] exp_q[$];

  // Reference model state
  bit         m_run;
  int         m_pos;
  int         m_cnt;
  logic [3:0] m_cq;
  logic [2:0] m_cp;
  bit         m_step;
  bit         m_wrap;

  int seg_steps;
  int seg_wraps;
  int edge_n;
  int last_step_edge;
  int prev_step_edge;

  typedef struct {
    logic [3:0] cmd;
    int         ncyc;
    logic [3:0] exp_led;
    int         exp_steps;
    int         exp_wraps;
  } vec_t;

  vec_t vecs[6];

  pio_led_sequencer #(
    .LED_W(LED_W),
    .TICK_DIV(TICK_DIV),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd(cmd),
    .led(led),
    .running(running),
    .step(step),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input logic rst_i, input logic [3:0] c);
    int period;
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (rst_i) begin
      m_run = 1'b0;
      m_pos = 0;
      m_cnt = 0;
      m_cq  = 4'b0;
      m_cp  = 3'b0;
      return;
    end
    period = TICK_DIV << m_cq[1:0];
    if (!m_run) begin
      if (m_cq[3]) begin
        m_run = 1'b1;
        m_pos = m_cq[2] ? LED_W - 1 : 0;
      end
      m_cnt = 0;
    end else if (!m_cq[3]) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (m_cq[2:0] != m_cp) begin
      m_cnt = 0;
    end else if (m_cnt == period - 1) begin
      m_cnt  = 0;
      m_step = 1'b1;
      if (m_cq[2]) begin
        m_wrap = (m_pos == 0);
        m_pos  = (m_pos == 0) ? LED_W - 1 : m_pos - 1;
      end else begin
        m_wrap = (m_pos == LED_W - 1);
        m_pos  = (m_pos == LED_W - 1) ? 0 : m_pos + 1;
      end
    end else begin
      m_cnt = m_cnt + 1;
    end
    m_cp = m_cq[2:0];
    m_cq = c;
  endfunction

  function automatic logic [6:0] model_out();
    logic [3:0] l;
    l = 4'b0001 << m_pos;
    if (!m_run) l = 4'b0000;
    return {l, m_run, m_step, m_wrap};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] c, input logic r);
    logic [6:0] e;
    @(negedge clk);
    cmd   = c;
    reset = r;
    model_edge(r, c);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    edge_n++;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty got=%b expected=entry", {led, running, step, wrap});
    end else begin
      e = exp_q.pop_front();
      if ({led, running, step, wrap} !== e) begin
        failures++;
        $display("FAIL sb_cycle edge=%0d got=%b expected=%b", edge_n, {led, running, step, wrap}, e);
      end
    end
    if (step === 1'b1) begin
      seg_steps++;
      prev_step_edge = last_step_edge;
      last_step_edge = edge_n;
    end
    if (wrap === 1'b1) seg_wraps++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{cmd: 4'b1000, ncyc: 16, exp_led: 4'b0001, exp_steps: 4, exp_wraps: 1};
    vecs[1] = '{cmd: 4'b0000, ncyc: 4,  exp_led: 4'b0000, exp_steps: 0, exp_wraps: 0};
    vecs[2] = '{cmd: 4'b1100, ncyc: 18, exp_led: 4'b1000, exp_steps: 4, exp_wraps: 1};
    vecs[3] = '{cmd: 4'b1011, ncyc: 66, exp_led: 4'b0010, exp_steps: 2, exp_wraps: 1};
    vecs[4] = '{cmd: 4'b1000, ncyc: 10, exp_led: 4'b1000, exp_steps: 2, exp_wraps: 0};
    vecs[5] = '{cmd: 4'b1000, ncyc: 14, exp_led: 4'b0100, exp_steps: 3, exp_wraps: 1};

    edge_n         = 0;
    last_step_edge = 0;
    prev_step_edge = 0;
    reset = 1'b1;
    cmd   = 4'b1000;
    model_edge(1'b1, 4'b0000);

    // Reset held three cycles with enable already requested
    for (int i = 0; i < 3; i++) cycle(4'b1000, 1'b1);
    check("reset_led", led, 0);
    check("reset_running", running, 0);
    check("reset_step", step, 0);

    // First LED appears two edges after release
    cycle(4'b1000, 1'b0);
    check("first_edge_led", led, 4'b0000);
    cycle(4'b1000, 1'b0);
    check("second_edge_led", led, 4'b0001);
    check("second_edge_running", running, 1);
    edge_n = 2;

    for (int v = 0; v < 6; v++) begin
      seg_steps = 0;
      seg_wraps = 0;
      for (int k = 0; k < vecs[v].ncyc; k++) cycle(vecs[v].cmd, 1'b0);
      check($sformatf("vec%0d_led", v), led, vecs[v].exp_led);
      check($sformatf("vec%0d_steps", v), seg_steps, vecs[v].exp_steps);
      check($sformatf("vec%0d_wraps", v), seg_wraps, vecs[v].exp_wraps);
      if (v == 3) check("speed3_step_gap", last_step_edge - prev_step_edge, 32);
    end

    // Direction change landing on the tick edge: no step, led holds
    cycle(4'b1100, 1'b0);
    cycle(4'b1100, 1'b0);
    check("coincide_led_hold", led, 4'b0100);
    check("coincide_no_step", step, 0);
    for (int k = 0; k < 3; k++) cycle(4'b1100, 1'b0);
    check("coincide_before_step", led, 4'b0100);
    cycle(4'b1100, 1'b0);
    check("coincide_new_led", led, 4'b0010);
    check("coincide_new_step", step, 1);

    // Disable: clears two edges after input change
    cycle(4'b0000, 1'b0);
    check("disable_edge1_running", running, 1);
    cycle(4'b0000, 1'b0);
    check("disable_led", led, 4'b0000);
    check("disable_running", running, 0);

    // Re-enable restarts at bit 0, not at last position
    cycle(4'b1000, 1'b0);
    cycle(4'b1000, 1'b0);
    check("reenable_led", led, 4'b0001);
    cycle(4'b1000, 1'b0);

    // Asynchronous reset mid-period clears outputs before the next clock edge
    @(negedge clk);
    #2;
    check("pre_async_running", running, 1);
    reset = 1'b1;
    #1;
    check("async_led", led, 4'b0000);
    check("async_running", running, 0);
    check("async_step", step, 0);
    model_edge(1'b1, 4'b0000);
    exp_q.delete();
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    check("post_reset_led", led, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
